// File: rtl/imem_pkg.sv
// Shared state encoding, sizing helpers and default constants for the instruction-memory block responder.
// The PREFETCH state exists only when IMEM_PREFETCH_EN is defined.
package imem_pkg;

  localparam int DEFAULT_READ_LATENCY    = 4;
  localparam int DEFAULT_MEM_DEPTH_WORDS = 1024;
  localparam int WORDS_PER_BLOCK         = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    DONE     = 2'd2
`ifdef IMEM_PREFETCH_EN
    ,
    PREFETCH = 2'd3
`endif
  } state_t;

  // Block address width: byte address minus the byte offset and the 2-bit word-in-block offset.
  function automatic int block_addr_width(input int address_width, input int instruction_size);
    return address_width - instruction_size - 2;
  endfunction

  function automatic int count_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/imem_word_array.sv
// Read-only word storage with a combinational 4-word block read; word indices wrap modulo the depth.
// Storage holds a built-in identity image (word i holds i); INIT_FILE is accepted for interface compatibility.
module imem_word_array
  import imem_pkg::*;
#(
  parameter int    INSTRUCTION_WIDTH   = 32,
  parameter int    BLOCK_ADDRESS_WIDTH = 28,
  parameter int    MEM_DEPTH_WORDS     = DEFAULT_MEM_DEPTH_WORDS,
  parameter string INIT_FILE           = "imem.hex"
) (
  input  logic [BLOCK_ADDRESS_WIDTH-1:0]               block_address,
  output logic [WORDS_PER_BLOCK*INSTRUCTION_WIDTH-1:0] block_data
);

  localparam int INDEX_WIDTH = $clog2(MEM_DEPTH_WORDS);

  logic [INSTRUCTION_WIDTH-1:0] words [MEM_DEPTH_WORDS];
  logic [INDEX_WIDTH-1:0]       base_index;

  generate
    for (genvar i = 0; i < MEM_DEPTH_WORDS; i++) begin : g_word
      assign words[i] = INSTRUCTION_WIDTH'(i);
    end
  endgenerate

  // Truncating to the index width is what makes the block wrap around the end of storage.
  assign base_index = INDEX_WIDTH'({block_address, 2'b00});

  always_comb begin
    block_data = '0;
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      block_data[k*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = words[base_index + INDEX_WIDTH'(k)];
    end
  end

endmodule

// File: rtl/i_mem_block_responder.sv
// Instruction-memory block responder: latches a 4-word block request and answers after READ_LATENCY cycles.
// Defining IMEM_PREFETCH_EN adds a one-block next-block prefetch buffer and a PREFETCH state.
module i_mem_block_responder
  import imem_pkg::*;
#(
  parameter int    INSTRUCTION_WIDTH = 32,
  parameter int    ADDRESS_WIDTH     = 32,
  parameter int    INSTRUCTION_SIZE  = $clog2(INSTRUCTION_WIDTH / 8),
  parameter int    MEM_DEPTH_WORDS   = DEFAULT_MEM_DEPTH_WORDS,
  parameter int    READ_LATENCY      = DEFAULT_READ_LATENCY,
  parameter string INIT_FILE         = "imem.hex",
  localparam int   BAW               = block_addr_width(ADDRESS_WIDTH, INSTRUCTION_SIZE)
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     mem_read,
  input  logic [BAW-1:0]                           mem_address,
  output logic [WORDS_PER_BLOCK*INSTRUCTION_WIDTH-1:0] mem_readdata,
  output logic                                     mem_busywait
);

  localparam int            BW          = WORDS_PER_BLOCK * INSTRUCTION_WIDTH;
  localparam int            CW          = count_width(READ_LATENCY);
  localparam logic [CW-1:0] COUNT_START = CW'(READ_LATENCY - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [BAW-1:0]  addr;
  logic [BW-1:0]   block;

  imem_word_array #(
    .INSTRUCTION_WIDTH  (INSTRUCTION_WIDTH),
    .BLOCK_ADDRESS_WIDTH(BAW),
    .MEM_DEPTH_WORDS    (MEM_DEPTH_WORDS),
    .INIT_FILE          (INIT_FILE)
  ) u_array (
    .block_address(addr),
    .block_data   (block)
  );

`ifdef IMEM_PREFETCH_EN
  logic           buffer_valid;
  logic [BAW-1:0] buffer_tag;
  logic [BW-1:0]  buffer_data;

  assign mem_busywait = (state == ACCESS) | (((state == IDLE) | (state == PREFETCH)) & mem_read);
`else
  assign mem_busywait = (state == ACCESS) | ((state == IDLE) & mem_read);
`endif

  // During PREFETCH, addr holds the block being fetched ahead, so one array port serves both paths.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      addr         <= '0;
      mem_readdata <= '0;
`ifdef IMEM_PREFETCH_EN
      buffer_valid <= 1'b0;
      buffer_tag   <= '0;
      buffer_data  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_read) begin
            addr <= mem_address;
`ifdef IMEM_PREFETCH_EN
            if (buffer_valid && (buffer_tag == mem_address)) begin
              mem_readdata <= buffer_data;
              state        <= DONE;
            end else begin
              count <= COUNT_START;
              state <= ACCESS;
            end
`else
            count <= COUNT_START;
            state <= ACCESS;
`endif
          end
        end

        ACCESS: begin
          if (!mem_read) begin
            state <= IDLE;
          end else if (count == '0) begin
            mem_readdata <= block;
            state        <= DONE;
          end else begin
            count <= count - CW'(1);
          end
        end

        DONE: begin
`ifdef IMEM_PREFETCH_EN
          addr         <= addr + BAW'(1);
          count        <= COUNT_START;
          buffer_valid <= 1'b0;
          state        <= PREFETCH;
`else
          state <= IDLE;
`endif
        end

`ifdef IMEM_PREFETCH_EN
        // A matching request rides on the in-flight fetch; any other request abandons it.
        PREFETCH: begin
          if (mem_read && (mem_address != addr)) begin
            buffer_valid <= 1'b0;
            addr         <= mem_address;
            count        <= COUNT_START;
            state        <= ACCESS;
          end else if (count == '0) begin
            if (mem_read) begin
              mem_readdata <= block;
              state        <= DONE;
            end else begin
              buffer_valid <= 1'b1;
              buffer_tag   <= addr;
              buffer_data  <= block;
              state        <= IDLE;
            end
          end else begin
            count <= count - CW'(1);
            if (mem_read) begin
              state <= ACCESS;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_block_responder.sv
// Self-checking bench for i_mem_block_responder using an identity image (word i holds i), READ_LATENCY=4.
// Cycle tables cover the default build; the prefetch sequence is compiled when IMEM_PREFETCH_EN is defined.
module tb_i_mem_block_responder;

  localparam int BAW = 28;
  localparam int BW  = 128;

  logic           clock = 1'b0;
  logic           reset;
  logic           mem_read;
  logic [BAW-1:0] mem_address;
  logic [BW-1:0]  mem_readdata;
  logic           mem_busywait;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           rst;
    logic           rd;
    logic [BAW-1:0] addr;
    logic           chk_busy;
    logic           exp_busy;
    logic           chk_data;
    logic [BW-1:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  i_mem_block_responder #(
    .INSTRUCTION_WIDTH(32),
    .ADDRESS_WIDTH    (32),
    .MEM_DEPTH_WORDS  (1024),
    .READ_LATENCY     (4),
    .INIT_FILE        ("")
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  // Expected block for an identity image starting at word w0, word 0 in the LSBs.
  function automatic logic [BW-1:0] blk(input int w0);
    return {32'(w0 + 3), 32'(w0 + 2), 32'(w0 + 1), 32'(w0)};
  endfunction

  function automatic void addVec(input logic rst, input logic rd, input logic [BAW-1:0] addr,
                                 input logic chk_busy, input logic exp_busy,
                                 input logic chk_data, input logic [BW-1:0] exp_data);
    vec_t v;
    v.rst      = rst;
    v.rd       = rd;
    v.addr     = addr;
    v.chk_busy = chk_busy;
    v.exp_busy = exp_busy;
    v.chk_data = chk_data;
    v.exp_data = exp_data;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    reset       = vecs[idx].rst;
    mem_read    = vecs[idx].rd;
    mem_address = vecs[idx].addr;
    @(negedge clock);
    if (vecs[idx].chk_busy)
      checkOutput($sformatf("vec%0d busywait", idx), BW'(mem_busywait), BW'(vecs[idx].exp_busy));
    if (vecs[idx].chk_data)
      checkOutput($sformatf("vec%0d readdata", idx), mem_readdata, vecs[idx].exp_data);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    mem_read = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("reset readdata", mem_readdata, '0);
    checkOutput("reset busywait idle", BW'(mem_busywait), BW'(1'b0));
    mem_read = 1'b1;
    #1;
    checkOutput("reset busywait follows read", BW'(mem_busywait), BW'(1'b1));
    @(posedge clock);
    #1;
    reset    = 1'b0;
    mem_read = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Holds mem_read until busywait drops, counting busy cycles; bounded so a stuck DUT still reaches the summary.
  task automatic measureRequest(input string name, input logic [BAW-1:0] addr,
                                input int exp_cycles, input logic [BW-1:0] exp_data);
    int cycles;
    bit done;
    cycles      = 0;
    done        = 1'b0;
    mem_read    = 1'b1;
    mem_address = addr;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (mem_busywait) begin
        cycles++;
        @(posedge clock);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: busywait still high after %0d cycles, required low after %0d", name, cycles, exp_cycles);
    end else begin
      checkOutput({name, " latency"}, BW'(cycles), BW'(exp_cycles));
      checkOutput({name, " data"}, mem_readdata, exp_data);
    end
    mem_read = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_address = '0;

`ifndef IMEM_PREFETCH_EN
    // Reset, then basic read of block 0x10.
    addVec(1, 0, 28'h0,   0, 0, 0, '0);
    addVec(1, 0, 28'h0,   1, 0, 1, '0);
    addVec(0, 0, 28'h0,   1, 0, 1, '0);
    addVec(0, 1, 28'h10,  1, 1, 1, '0);
    for (int i = 0; i < 4; i++) addVec(0, 1, 28'h10, 1, 1, 0, '0);
    // DONE: requester keeps mem_read high and moves on to block 0x11.
    addVec(0, 1, 28'h11,  1, 0, 1, blk(32'h40));
    addVec(0, 1, 28'h11,  1, 1, 1, blk(32'h40));
    for (int i = 0; i < 4; i++) addVec(0, 1, 28'h55, 1, 1, 0, '0);
    addVec(0, 0, 28'h55,  1, 0, 1, blk(32'h44));
    addVec(0, 0, 28'h0,   1, 0, 1, blk(32'h44));
    // Abort: mem_read drops at T0+2.
    addVec(0, 1, 28'h20,  1, 1, 0, '0);
    addVec(0, 1, 28'h20,  1, 1, 0, '0);
    addVec(0, 0, 28'h20,  1, 1, 0, '0);
    addVec(0, 0, 28'h20,  1, 0, 1, blk(32'h44));
    addVec(0, 0, 28'h20,  1, 0, 1, blk(32'h44));
    // Reset at T0+2 of a request.
    addVec(0, 1, 28'h30,  1, 1, 0, '0);
    addVec(0, 1, 28'h30,  1, 1, 0, '0);
    addVec(1, 1, 28'h30,  1, 1, 0, '0);
    addVec(0, 0, 28'h30,  1, 0, 1, '0);
    // Wrap: block 0x100 maps onto words 0..3 of a 1024-word store.
    addVec(0, 1, 28'h100, 1, 1, 1, '0);
    for (int i = 0; i < 4; i++) addVec(0, 1, 28'h100, 1, 1, 0, '0);
    addVec(0, 0, 28'h100, 1, 0, 1, blk(0));
    addVec(0, 0, 28'h0,   1, 0, 1, blk(0));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);
`endif

    doReset();
    measureRequest("last block wrap", 28'h3FF, 5, blk(32'h3FC));

`ifdef IMEM_PREFETCH_EN
    measureRequest("pf miss 0x10", 28'h10, 5, blk(32'h40));
    mem_read = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    measureRequest("pf hit 0x11", 28'h11, 1, blk(32'h44));
    measureRequest("pf abort 0x30", 28'h30, 5, blk(32'hC0));
    measureRequest("pf in-flight 0x31", 28'h31, 4, blk(32'hC4));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
